// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision reciprocal pipeline and its front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_pkg;

    // Default depth of the reciprocal pipeline, valid-in to valid-out, in cycles.
    localparam int FP_RECIP_LAT = 16;

    // Rounding-mode encoding is owned by the pipeline; the arbiter only forwards it.
    typedef logic [2:0] fp_rm_t;

    // Result flags. MSB first: {overflow, underflow, inexact, invalid_operation}.
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic invalid_operation;
    } fp_flags_t;

    // Width of a requester index. A single requester still needs a 1-bit id field.
    function automatic int fp_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_recip_arbiter_if.sv
// Bundle of request, pipeline-issue, pipeline-return and response signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: req_* is valid/ready; pipeline and response sides have none.
//   master: the arbiter (drives req_ready, pipe issue bus, response bus, tag_error, busy)
//   slave : requesters + pipeline + response sink (drive req_*, pipe_*_out, pipe_flags)
interface fp_recip_arbiter_if #(
    parameter int N_REQ = 4
);
    import fp_pkg::*;

    localparam int ID_W = fp_id_width(N_REQ);

    // Requesters
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0][31:0]   req_data;
    logic [N_REQ-1:0][2:0]    req_rm;
    logic [N_REQ-1:0]         req_ready;

    // Issue bus towards the pipeline
    logic                     pipe_valid_in;
    logic [31:0]              pipe_in;
    fp_rm_t                   pipe_rounding_mode;

    // Return bus from the pipeline
    logic                     pipe_valid_out;
    logic [31:0]              pipe_out;
    fp_flags_t                pipe_flags;

    // Routed response
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [31:0]              resp_data;
    fp_flags_t                resp_flags;

    // Status
    logic                     tag_error;
    logic                     busy;

    modport master (
        input  req_valid, req_data, req_rm,
        input  pipe_valid_out, pipe_out, pipe_flags,
        output req_ready,
        output pipe_valid_in, pipe_in, pipe_rounding_mode,
        output resp_valid, resp_id, resp_data, resp_flags,
        output tag_error, busy
    );

    modport slave (
        output req_valid, req_data, req_rm,
        output pipe_valid_out, pipe_out, pipe_flags,
        input  req_ready,
        input  pipe_valid_in, pipe_in, pipe_rounding_mode,
        input  resp_valid, resp_id, resp_data, resp_flags,
        input  tag_error, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant is all-zero when nothing is eligible.
//   eligible [N]  : per-index request qualified by the caller
//   ptr      [PW] : index where the search starts (highest priority this cycle)
//   grant    [N]  : one-hot (or zero) winner
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int              idx;
    logic [PW-1:0]   sel;
    logic            found;

    // Walk N positions starting at ptr; the first eligible one wins. Wrapping is
    // done on an int so non-power-of-two N stays correct.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = PW'(idx);
            if (!found && eligible[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_recip_arbiter.sv
// Shares one fixed-latency reciprocal pipeline among N_REQ requesters; routes results back by tag.
// Latency: request transfer to resp_valid is LAT+2 cycles (registered issue + registered response).
// Backpressure: per-requester credit (MAX_OUT in flight) gates req_ready; responses cannot be stalled.
//   clk, rst_n : clock, asynchronous active-low reset (shared with the pipeline)
//   bus        : fp_recip_arbiter_if.master -- req_*, pipe_* issue/return, resp_*, tag_error, busy
module fp_recip_arbiter
    import fp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LAT     = FP_RECIP_LAT,
    parameter int MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_recip_arbiter_if.master bus
);

    localparam int ID_W  = fp_id_width(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    // Tag travelling alongside each operation inside the pipeline.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] req_ready;
    logic             xfer;
    logic [ID_W-1:0]  xfer_id;

    logic [ID_W-1:0]  rr_ptr_q,        rr_ptr_d;
    logic             pipe_valid_in_q, pipe_valid_in_d;
    logic [31:0]      pipe_in_q,       pipe_in_d;
    fp_rm_t           pipe_rm_q,       pipe_rm_d;
    logic [ID_W-1:0]  issue_id_q,      issue_id_d;

    tag_t             tag_q [LAT];
    tag_t             tag_d [LAT];
    tag_t             tail;

    logic             resp_valid_q,    resp_valid_d;
    logic [ID_W-1:0]  resp_id_q,       resp_id_d;
    logic [31:0]      resp_data_q,     resp_data_d;
    fp_flags_t        resp_flags_q,    resp_flags_d;
    logic             tag_error_q,     tag_error_d;

    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];
    logic [N_REQ-1:0] cnt_inc;
    logic [N_REQ-1:0] cnt_dec;
    logic             cnt_underflow;
    logic             busy;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N  (N_REQ),
        .PW (ID_W)
    ) u_rr_arbiter (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .grant    (grant)
    );

    // Ready is forced low while reset is held, since counters at zero would
    // otherwise make every valid requester look eligible.
    always_comb begin
        req_ready = rst_n ? grant : '0;
        xfer      = |req_ready;
        xfer_id   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                xfer_id = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer and issue stage
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        pipe_valid_in_d = xfer;
        pipe_in_d       = pipe_in_q;
        pipe_rm_d       = pipe_rm_q;
        issue_id_d      = issue_id_q;
        if (xfer) begin
            rr_ptr_d   = (int'(xfer_id) == N_REQ - 1) ? '0 : xfer_id + ID_W'(1);
            pipe_in_d  = bus.req_data[xfer_id];
            pipe_rm_d  = bus.req_rm[xfer_id];
            issue_id_d = xfer_id;
        end
    end

    // ------------------------------------------------------------------
    // Tag shift register. Entry 0 is loaded from the issue register, so the
    // tail (entry LAT-1) lines up with the cycle the pipeline raises valid_out.
    // ------------------------------------------------------------------
    always_comb begin
        tag_d[0].vld = pipe_valid_in_q;
        tag_d[0].id  = issue_id_q;
        for (int k = 1; k < LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        tail = tag_q[LAT-1];
    end

    // ------------------------------------------------------------------
    // Response stage. An untagged pipeline result is dropped; a tagged slot
    // with no pipeline result is simply lost. Either way the mismatch is
    // recorded in the sticky error.
    // ------------------------------------------------------------------
    always_comb begin
        resp_valid_d = bus.pipe_valid_out && tail.vld;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;
        if (resp_valid_d) begin
            resp_id_d    = tail.id;
            resp_data_d  = bus.pipe_out;
            resp_flags_d = bus.pipe_flags;
        end
    end

    // ------------------------------------------------------------------
    // Per-requester in-flight counters. Increment is already bounded by the
    // eligibility check, so only the decrement side needs a guard.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_inc[i] = xfer && (xfer_id == ID_W'(i));
            cnt_dec[i] = resp_valid_q && (resp_id_q == ID_W'(i));
        end
    end

    always_comb begin
        cnt_underflow = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_inc[i] && !cnt_dec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
                if (cnt_q[i] == '0) begin
                    cnt_underflow = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        tag_error_d = tag_error_q
                    | (bus.pipe_valid_out != tail.vld)
                    | cnt_underflow;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            busy = busy | (cnt_q[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q        <= '0;
            pipe_valid_in_q <= 1'b0;
            pipe_in_q       <= '0;
            pipe_rm_q       <= '0;
            issue_id_q      <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_data_q     <= '0;
            resp_flags_q    <= '0;
            tag_error_q     <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            pipe_valid_in_q <= pipe_valid_in_d;
            pipe_in_q       <= pipe_in_d;
            pipe_rm_q       <= pipe_rm_d;
            issue_id_q      <= issue_id_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_data_q     <= resp_data_d;
            resp_flags_q    <= resp_flags_d;
            tag_error_q     <= tag_error_d;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready          = req_ready;
    assign bus.pipe_valid_in      = pipe_valid_in_q;
    assign bus.pipe_in            = pipe_in_q;
    assign bus.pipe_rounding_mode = pipe_rm_q;
    assign bus.resp_valid         = resp_valid_q;
    assign bus.resp_id            = resp_id_q;
    assign bus.resp_data          = resp_data_q;
    assign bus.resp_flags         = resp_flags_q;
    assign bus.tag_error          = tag_error_q;
    assign bus.busy               = busy;

endmodule

// File: tb/tb_fp_recip_arbiter.sv
// Directed bench for fp_recip_arbiter with a fixed-latency pipeline stand-in.
// The stand-in returns exact reciprocals of power-of-two operands and echoes rm into the low flag bits.
module tb_fp_recip_arbiter;
    import fp_pkg::*;

    localparam int N_REQ   = 4;
    localparam int LAT     = 16;
    localparam int MAX_OUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_recip_arbiter_if #(.N_REQ(N_REQ)) bus();

    fp_recip_arbiter #(
        .N_REQ   (N_REQ),
        .LAT     (LAT),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- pipeline stand-in ----------------
    function automatic logic [31:0] recip_pow2(input logic [31:0] x);
        logic [8:0] e;
        e = 9'd254 - {1'b0, x[30:23]};
        return {x[31], e[7:0], 23'd0};
    endfunction

    logic [LAT-1:0] pv;
    logic [31:0]    pd [LAT];
    logic [2:0]     pr [LAT];
    logic           inject;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], bus.pipe_valid_in};
            pd[0] <= recip_pow2(bus.pipe_in);
            pr[0] <= bus.pipe_rounding_mode;
            for (int k = 1; k < LAT; k++) begin
                pd[k] <= pd[k-1];
                pr[k] <= pr[k-1];
            end
        end
    end

    assign bus.pipe_valid_out = pv[LAT-1] | inject;
    assign bus.pipe_out       = pd[LAT-1];
    assign bus.pipe_flags     = {1'b0, pr[LAT-1]};

    // ---------------- cycle count and response log ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          q_id[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_flags[$];
    int          q_cyc[$];

    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            q_id.push_back(int'(bus.resp_id));
            q_data.push_back(bus.resp_data);
            q_flags.push_back(bus.resp_flags);
            q_cyc.push_back(cyc);
        end
    end

    // ---------------- checking ----------------
    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_id.delete(); q_data.delete(); q_flags.delete(); q_cyc.delete();
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k = 0;
        while (q_id.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("resp_count", 32'(q_id.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            tick();
            k++;
        end
        chk("idle", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  {28'd0, bus.req_ready}, 32'd0);
        chk({tag, "_pvin"},       {31'd0, bus.pipe_valid_in}, 32'd0);
        chk({tag, "_pipe_in"},    bus.pipe_in, 32'd0);
        chk({tag, "_pipe_rm"},    {29'd0, bus.pipe_rounding_mode}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_id"},    {30'd0, bus.resp_id}, 32'd0);
        chk({tag, "_resp_data"},  bus.resp_data, 32'd0);
        chk({tag, "_resp_flags"}, {28'd0, bus.resp_flags}, 32'd0);
        chk({tag, "_tag_error"},  {31'd0, bus.tag_error}, 32'd0);
        chk({tag, "_busy"},       {31'd0, bus.busy}, 32'd0);
    endtask

    logic [31:0] op_data  [4];
    logic [31:0] exp_data [4];
    int t0;

    initial begin
        // Operands 2, 4, 8, 16 and their reciprocals 0.5, 0.25, 0.125, 0.0625.
        op_data[0]  = 32'h4000_0000; exp_data[0] = 32'h3F00_0000;
        op_data[1]  = 32'h4080_0000; exp_data[1] = 32'h3E80_0000;
        op_data[2]  = 32'h4100_0000; exp_data[2] = 32'h3E00_0000;
        op_data[3]  = 32'h4180_0000; exp_data[3] = 32'h3D80_0000;

        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_rm    = '0;
        inject        = 1'b0;
        rst_n         = 1'b0;

        // ---- reset state, with every requester asking ----
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("rst");
        tick();
        rst_n = 1'b1;
        bus.req_valid = '0;

        // ---- single request from requester 2 ----
        clear_q();
        bus.req_valid       = 4'b0100;
        bus.req_data[2]     = 32'h4000_0000;
        bus.req_rm[2]       = 3'd0;
        @(negedge clk);
        t0 = cyc;
        chk("single_grant", {28'd0, bus.req_ready}, 32'h4);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_pvin",  {31'd0, bus.pipe_valid_in}, 32'd1);
        chk("single_pin",   bus.pipe_in, 32'h4000_0000);
        chk("single_prm",   {29'd0, bus.pipe_rounding_mode}, 32'd0);
        chk("single_busy",  {31'd0, bus.busy}, 32'd1);
        wait_resp(1, 40);
        chk("single_lat",   32'(q_cyc[0] - t0), 32'd18);
        chk("single_id",    32'(q_id[0]), 32'd2);
        chk("single_data",  q_data[0], 32'h3F00_0000);
        chk("single_flags", {28'd0, q_flags[0]}, 32'd0);
        @(negedge clk);
        chk("single_busy_after", {31'd0, bus.busy}, 32'd0);
        chk("single_no_err",     {31'd0, bus.tag_error}, 32'd0);

        // ---- all four valid from reset: strict rotation, in-order return ----
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            bus.req_data[i] = op_data[i];
            bus.req_rm[i]   = 3'(i + 1);
        end
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) t0 = cyc;
            chk("rr_grant", {28'd0, bus.req_ready}, 32'd1 << (k % 4));
            tick();
        end
        bus.req_valid = '0;
        wait_resp(8, 40);
        for (int k = 0; k < 8; k++) begin
            chk("rr_resp_id",    32'(q_id[k]), 32'(k % 4));
            chk("rr_resp_data",  q_data[k], exp_data[k % 4]);
            chk("rr_resp_flags", {28'd0, q_flags[k]}, 32'((k % 4) + 1));
            chk("rr_resp_cyc",   32'(q_cyc[k] - t0), 32'(18 + k));
        end
        wait_idle(40);

        // ---- credit limit on requester 1 ----
        clear_q();
        bus.req_data[1] = op_data[1];
        bus.req_valid   = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) t0 = cyc;
            chk("credit_ready", {28'd0, bus.req_ready},
                (k < 4 || k == 19) ? 32'h2 : 32'h0);
            if (k == 18) begin
                chk("credit_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
                chk("credit_resp_id",    {30'd0, bus.resp_id}, 32'd1);
            end
            tick();
        end
        bus.req_valid = '0;
        wait_idle(60);

        // ---- simultaneous transfer and response on requester 0 ----
        clear_q();
        bus.req_data[0] = op_data[0];
        for (int k = 0; k < 20; k++) begin
            bus.req_valid = (k < 2 || k == 18) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (k == 17) chk("same_cnt_before", 32'(dut.cnt_q[0]), 32'd2);
            if (k == 18) begin
                chk("same_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
                chk("same_resp_id",    {30'd0, bus.resp_id}, 32'd0);
                chk("same_ready",      {28'd0, bus.req_ready}, 32'h1);
            end
            if (k == 19) chk("same_cnt_after", 32'(dut.cnt_q[0]), 32'd2);
            tick();
        end
        bus.req_valid = '0;
        wait_idle(60);

        // ---- spurious pipeline result ----
        clear_q();
        inject = 1'b1;
        @(negedge clk);
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("spur_err",        {31'd0, bus.tag_error}, 32'd1);
        chk("spur_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        repeat (3) tick();
        chk("spur_err_hold",   {31'd0, bus.tag_error}, 32'd1);
        chk("spur_no_resp",    32'(q_id.size()), 32'd0);

        // ---- reset with five operations in flight ----
        clear_q();
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) begin
                chk("midrst_err_sticky", {31'd0, bus.tag_error}, 32'd1);
                chk("midrst_busy",       {31'd0, bus.busy}, 32'd1);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        bus.req_valid = '0;
        repeat (LAT + 8) tick();
        chk("midrst_no_stale", 32'(q_id.size()), 32'd0);
        chk("midrst_idle",     {31'd0, bus.busy}, 32'd0);
        bus.req_valid = '1;
        @(negedge clk);
        chk("midrst_ptr_reset", {28'd0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = '0;
        wait_idle(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_recip_arbiter.md
FP_RECIP_ARBITER -- requirements
Module: fp_recip_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters sharing one reciprocal pipeline.
REQ-002 The block SHALL have parameter LAT, default 16: fixed pipeline latency, pipe_valid_in to pipe_valid_out, in cycles.
REQ-003 The block SHALL have parameter MAX_OUT, default 4: maximum in-flight operations per requester.
REQ-004 The block SHALL have port clk  in  1: single clock; all logic is posedge.
REQ-005 The block SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid  in  N_REQ: per-requester operation request.
REQ-007 The block SHALL have port req_data  in  N_REQ x 32: single-precision operand per requester.
REQ-008 The block SHALL have port req_rm  in  N_REQ x 3: rounding mode per requester.
REQ-009 The block SHALL have port req_ready  out  N_REQ: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 The block SHALL have ports pipe_valid_in  out  1, pipe_in  out  32 and pipe_rounding_mode  out  3: issue bus to the pipeline.
REQ-011 The block SHALL have ports pipe_valid_out  in  1, pipe_out  in  32 and pipe_flags  in  4: pipeline result, with flags {overflow, underflow, inexact, invalid_operation}.
REQ-012 The block SHALL have ports resp_valid  out  1, resp_id  out  clog2(N_REQ), resp_data  out  32 and resp_flags  out  4: routed result; there is no backpressure.
REQ-013 The block SHALL have port tag_error  out  1: sticky error, cleared only by reset.
REQ-014 The block SHALL have port busy  out  1: high while any operation is in flight.

Function
REQ-015 Requester i SHALL be eligible when req_valid[i]=1 and outstanding[i] < MAX_OUT.
REQ-016 Grant SHALL be combinational round-robin among eligible requesters, starting search at rr_ptr; req_ready SHALL be at most one-hot, and all-zero when no requester is eligible.
REQ-017 On a transfer by requester g, rr_ptr SHALL become (g+1) mod N_REQ; with no transfer, rr_ptr SHALL hold.
REQ-018 The issue stage SHALL be registered: a transfer in cycle t SHALL give pipe_valid_in=1 in cycle t+1, with pipe_in=req_data[g] and pipe_rounding_mode=req_rm[g].
REQ-019 With no transfer in cycle t, pipe_valid_in SHALL be 0 in cycle t+1 and pipe_in/pipe_rounding_mode SHALL hold.
REQ-020 A tag shift register of depth LAT SHALL carry {valid, id} in lockstep with pipe_valid_in; its tail SHALL be aligned with pipe_valid_out.
REQ-021 The response stage SHALL be registered: pipe_valid_out in cycle u SHALL give resp_valid=1 in cycle u+1, with resp_id=tail id, resp_data=pipe_out, resp_flags=pipe_flags. Total request-to-response latency is LAT+2.
REQ-022 If pipe_valid_out differs from tail valid, tag_error SHALL set; when the tag is invalid, no resp_valid SHALL be produced and no counter SHALL change.
REQ-023 outstanding[i] (width clog2(MAX_OUT+1)) SHALL increment on a transfer from i and decrement on resp_valid with resp_id=i; both in the same cycle SHALL leave it unchanged.
REQ-024 outstanding[i] SHALL never exceed MAX_OUT or wrap below 0; an underflow attempt SHALL set tag_error and hold the counter at 0.
REQ-025 busy SHALL be the OR of all nonzero outstanding counters.
REQ-026 When all requesters are continuously valid with credit, the block SHALL issue one operation per cycle (full throughput) and rotate grants strictly.

Reset
REQ-027 While rst_n=0: req_ready=0, pipe_valid_in=0, pipe_in=0, pipe_rounding_mode=0, resp_valid=0, resp_id=0, resp_data=0, resp_flags=0, tag_error=0, busy=0, rr_ptr=0, all counters=0, all tag entries invalid.
REQ-028 Reset asserted mid-operation SHALL drop every in-flight tag; no stale response SHALL be emitted after deassertion. The pipeline shares the same reset.

Structure
REQ-029 The flag bundle type and its bit ordering SHALL be defined in fp_pkg; LAT default SHALL be a named constant in fp_pkg.
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arbiter (parameter N, inputs eligible and ptr, output one-hot grant).

Verification
REQ-031 Single request: req_valid[2]=1, data 0x40000000, rm=0 at t -> pipe_valid_in at t+1; pipeline returns 0x3F000000 -> resp_valid at t+18, resp_id=2, resp_data=0x3F000000.
REQ-032 All four requesters valid continuously from reset -> grants 0,1,2,3,0,... one per cycle; responses return in the same id order LAT+2 later.
REQ-033 Requester 1 issues 4 operations with no response yet -> req_ready[1]=0 while req_valid[1]=1; it regains ready the cycle after its first resp_valid.
REQ-034 Simultaneous transfer and response for id 0 with outstanding[0]=2 -> counter stays at 2.
REQ-035 Spurious pipe_valid_out with no valid tag -> tag_error=1, resp_valid stays 0, and tag_error persists until rst_n=0.
REQ-036 rst_n pulsed low with 5 operations in flight -> all outputs go to reset values immediately; no resp_valid afterwards; busy=0.
